// File: rtl/game2048_pkg.sv
// game2048_pkg: key codes seen by the 2048 game FSM and the keypad scanner state encoding.
package game2048_pkg;
    localparam logic [3:0] KEY_LEFT  = 4'h1;
    localparam logic [3:0] KEY_RIGHT = 4'h3;
    localparam logic [3:0] KEY_UP    = 4'h6;
    localparam logic [3:0] KEY_DOWN  = 4'h2;
    typedef enum logic [1:0] {SCAN, DEB_P, HELD, DEB_R} scan_state_e;
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running prescaler emitting a one-clk tick every SCAN_DIV clocks.
module scan_tick_gen #(
    parameter int SCAN_DIV = 33000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(SCAN_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == CW'(SCAN_DIV - 1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: scans a 4x4 active-low matrix and debounces a single key into a code,
// a held level and press/release pulses.
module keypad_scan_debounce
    import game2048_pkg::*;
#(
    parameter int SCAN_DIV       = 33000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] code,
    output logic       keydown,
    output logic       key_press,
    output logic       key_release
);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_TICKS);
    scan_state_e state_q, state_d;
    logic [1:0]    ridx_q, ridx_d, cidx_q, cidx_d, low_col;
    logic [DW-1:0] dcnt_q, dcnt_d, dinc;
    logic [3:0]    cs1_q, cs_q, code_q, code_d;
    logic          keydown_q, keydown_d, press_q, press_d, release_q, release_d;
    logic          tick, hit;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    assign low_col = !cs_q[0] ? 2'd0 : !cs_q[1] ? 2'd1 : !cs_q[2] ? 2'd2 : 2'd3;
    assign hit     = !cs_q[cidx_q];
    assign dinc    = dcnt_q == DMAX ? dcnt_q : dcnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ridx_d    = ridx_q;
        cidx_d    = cidx_q;
        dcnt_d    = dcnt_q;
        code_d    = code_q;
        keydown_d = keydown_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN:  if (cs_q == 4'hF) ridx_d = ridx_q + 2'd1;
                       else begin
                           cidx_d  = low_col;
                           dcnt_d  = DW'(1);
                           state_d = DEB_P;
                       end
                DEB_P: if (hit) dcnt_d = dinc;
                       else begin
                           ridx_d  = ridx_q + 2'd1;
                           state_d = SCAN;
                       end
                HELD:  if (!hit) begin
                           dcnt_d  = DW'(1);
                           state_d = DEB_R;
                       end
                DEB_R: if (hit) state_d = HELD;
                       else dcnt_d = dinc;
            endcase
            // Acceptance checks the updated count so DEBOUNCE_TICKS=1 resolves on the entry tick.
            if (state_d == DEB_P && dcnt_d == DMAX) begin
                code_d    = {ridx_q, cidx_d};
                keydown_d = 1'b1;
                press_d   = 1'b1;
                state_d   = HELD;
            end
            if (state_d == DEB_R && dcnt_d == DMAX) begin
                keydown_d = 1'b0;
                release_d = 1'b1;
                ridx_d    = ridx_q + 2'd1;
                state_d   = SCAN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs1_q     <= 4'hF;
            cs_q      <= 4'hF;
            state_q   <= SCAN;
            ridx_q    <= '0;
            cidx_q    <= '0;
            dcnt_q    <= '0;
            code_q    <= '0;
            keydown_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cs1_q     <= col;
            cs_q      <= cs1_q;
            state_q   <= state_d;
            ridx_q    <= ridx_d;
            cidx_q    <= cidx_d;
            dcnt_q    <= dcnt_d;
            code_q    <= code_d;
            keydown_q <= keydown_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign row         = ~(4'b0001 << ridx_q);
    assign code        = code_q;
    assign keydown     = keydown_q;
    assign key_press   = press_q;
    assign key_release = release_q;
endmodule
